// File: rtl/branch_predictor.sv
// Tournament branch predictor: bimodal + gshare with a per-PC chooser and a direct-mapped BTB.
// Optional event counters are built only when CHRONOS_BP_PERF_EN is defined.
module branch_predictor #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned GHR_BITS    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_val,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [31:0]         upd_target,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_mispred,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispred
);

  localparam int unsigned PHT_IW = $clog2(PHT_ENTRIES);
  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W  = 30 - BTB_IW;

  logic [1:0]          bim_tbl [PHT_ENTRIES];
  logic [1:0]          gsh_tbl [PHT_ENTRIES];
  logic [1:0]          cho_tbl [PHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]    btb_tag [BTB_ENTRIES];
  logic [31:0]         btb_tgt [BTB_ENTRIES];
  logic [GHR_BITS-1:0] ghr;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  // Lookup path
  logic [PHT_IW-1:0] lk_idx;
  logic [PHT_IW-1:0] lk_gidx;
  logic [BTB_IW-1:0] lk_bidx;
  logic [TAG_W-1:0]  lk_tag;
  logic [1:0]        lk_ctr;
  logic              lk_hit;

  always_comb begin
    lk_idx  = pred_pc[PHT_IW+1:2];
    lk_gidx = lk_idx ^ PHT_IW'(ghr);
    lk_bidx = pred_pc[BTB_IW+1:2];
    lk_tag  = pred_pc[31:BTB_IW+2];
    lk_ctr  = cho_tbl[lk_idx][1] ? gsh_tbl[lk_gidx] : bim_tbl[lk_idx];
    lk_hit  = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
  end

  always_comb begin
    pred_taken  = !rst && lk_hit && lk_ctr[1];
    pred_target = pred_taken ? btb_tgt[lk_bidx] : pred_pc + 32'd4;
    pred_ghr    = ghr;
  end

  // Update path
  logic [PHT_IW-1:0] up_idx;
  logic [PHT_IW-1:0] up_gidx;
  logic [BTB_IW-1:0] up_bidx;
  logic [TAG_W-1:0]  up_tag;
  logic [1:0]        up_bim_old;
  logic [1:0]        up_gsh_old;

  always_comb begin
    up_idx     = upd_pc[PHT_IW+1:2];
    up_gidx    = up_idx ^ PHT_IW'(upd_ghr);
    up_bidx    = upd_pc[BTB_IW+1:2];
    up_tag     = upd_pc[31:BTB_IW+2];
    up_bim_old = bim_tbl[up_idx];
    up_gsh_old = gsh_tbl[up_gidx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        bim_tbl[i] <= 2'b01;
        gsh_tbl[i] <= 2'b01;
        cho_tbl[i] <= 2'b01;
      end
      btb_valid <= '0;
      ghr       <= '0;
    end else if (upd_val) begin
      bim_tbl[up_idx]  <= sat2(up_bim_old, upd_taken);
      gsh_tbl[up_gidx] <= sat2(up_gsh_old, upd_taken);
      // Chooser only learns when the two components disagreed before this update
      if (up_bim_old[1] != up_gsh_old[1])
        cho_tbl[up_idx] <= sat2(cho_tbl[up_idx], up_gsh_old[1] == upd_taken);
      if (upd_taken)
        btb_valid[up_bidx] <= 1'b1;
      ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
    end
  end

  // BTB payload needs no reset; entries are masked by btb_valid
  always_ff @(posedge clk) begin
    if (upd_val && upd_taken && !rst) begin
      btb_tag[up_bidx] <= up_tag;
      btb_tgt[up_bidx] <= upd_target;
    end
  end

`ifdef CHRONOS_BP_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (upd_val) begin
      perf_branches <= perf_branches + 32'd1;
      if (upd_mispred)
        perf_mispred <= perf_mispred + 32'd1;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0], upd_mispred};
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16: BTB entry count, power of 2.
REQ-002 SHALL have parameter PHT_ENTRIES, default 64: entries in each of the bimodal, gshare and chooser tables, power of 2.
REQ-003 SHALL have parameter GHR_BITS, default 6: global history length, at most log2(PHT_ENTRIES).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port pred_pc, input, 32 bits: fetch PC being looked up (IF-stage if_pc).
REQ-007 SHALL have port pred_taken, output, 1 bit: predicted taken; fetch selects PCMUX_PRED_TGT when high.
REQ-008 SHALL have port pred_target, output, 32 bits: predicted next PC.
REQ-009 SHALL have port pred_ghr, output, GHR_BITS: history snapshot piped with the instruction.
REQ-010 SHALL have port upd_val, input, 1 bit: a branch or jump resolved in EX this cycle.
REQ-011 SHALL have port upd_pc, input, 32 bits: PC of the resolved instruction.
REQ-012 SHALL have port upd_taken, input, 1 bit: actual direction.
REQ-013 SHALL have port upd_target, input, 32 bits: actual target.
REQ-014 SHALL have port upd_ghr, input, GHR_BITS: the pred_ghr captured when upd_pc was fetched.
REQ-015 SHALL have port upd_mispred, input, 1 bit: EX detected a direction or target mispredict.
REQ-016 SHALL have ports perf_branches and perf_mispred, output, 32 bits each: event counters (see REQ-031).

Function
REQ-017 SHALL index bimodal and chooser with pc[log2(PHT_ENTRIES)+1:2], and gshare with that field XOR the zero-extended GHR.
REQ-018 SHALL index the BTB with pc[log2(BTB_ENTRIES)+1:2] and tag it with pc[31:log2(BTB_ENTRIES)+2].
REQ-019 SHALL perform lookup combinationally (zero latency): chosen counter = gshare if chooser bit1 = 1, else bimodal.
REQ-020 SHALL drive pred_taken = BTB hit (valid and tag match) AND chosen counter bit1; pred_target = BTB target if pred_taken, else pred_pc+4.
REQ-021 SHALL drive pred_ghr = current GHR register.
REQ-022 SHALL, on a posedge with upd_val = 1, update the bimodal counter at index(upd_pc) and the gshare counter at index(upd_pc) XOR upd_ghr as 2-bit saturating counters: +1 if taken (saturate at 3), -1 if not taken (saturate at 0).
REQ-023 SHALL update the chooser only when the pre-update bimodal and gshare bit1 values differ: +1 if gshare was correct, -1 if bimodal was correct, saturating at 0 and 3.
REQ-024 SHALL, on upd_val AND upd_taken, write the BTB entry valid = 1, with tag and target = upd_target; not-taken updates SHALL leave the BTB unchanged.
REQ-025 SHALL, on upd_val, load GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken} (non-speculative repair from the snapshot); otherwise GHR holds.
REQ-026 SHALL return pre-update table contents when lookup and update hit the same entry in the same cycle; the new value becomes visible the following cycle.
REQ-027 SHALL ignore upd_taken, upd_target, upd_ghr and upd_mispred whenever upd_val = 0.

Reset
REQ-028 SHALL asynchronously set all bimodal and gshare counters to 2'b01 (weakly not-taken), chooser counters to 2'b01 (weakly bimodal), BTB valid bits to 0, GHR to 0, and perf counters to 0.
REQ-029 SHALL, while rst is high, output pred_taken = 0, pred_target = pred_pc+4, pred_ghr = 0, and ignore updates.
REQ-030 SHALL accept the first update at the first posedge after rst deasserts.

Configuration
REQ-031 SHALL, with CHRONOS_BP_PERF_EN defined, increment perf_branches on each posedge with upd_val = 1 and perf_mispred on each posedge with upd_val AND upd_mispred; both wrap 0xFFFFFFFF -> 0.
REQ-032 SHALL, without CHRONOS_BP_PERF_EN, tie perf_branches and perf_mispred to 0 and instantiate no counter flops.

Verification
REQ-033 SHALL cover: reset, lookup 0x100 -> pred_taken 0, pred_target 0x104, pred_ghr 0.
REQ-034 SHALL cover: two taken updates of 0x100 with target 0x200, then lookup 0x100 -> pred_taken 1, pred_target 0x200.
REQ-035 SHALL cover: lookup 0x100 in the same cycle as its first taken update -> pred_taken 0; next cycle, counter and BTB show the updated values.
REQ-036 SHALL cover: five not-taken updates then one taken update of 0x100 -> bimodal counter 1, pred_taken 0.
REQ-037 SHALL cover: train 0x100 taken, then lookup 0x140 (same BTB index, different tag) -> pred_taken 0, pred_target 0x144.
REQ-038 SHALL cover: 10 updates of which 3 have upd_mispred -> perf_branches 10, perf_mispred 3 with CHRONOS_BP_PERF_EN; both 0 without it.
